// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Fetch entries pair an instruction word with the PC it was fetched from.
package ifu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of fetch entries with synchronous flush and occupancy count.
// Flush wins over push/pop in the same cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always @(posedge clk) begin
        if (!reset && !flush) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC owner: issues word requests, tracks in-flight and stale responses,
// and buffers returned instructions with their PCs for decode.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   drop_redirect;
    logic [CW:0]     pending;
    logic [CW:0]     occupancy;

    logic [CW-1:0]   pcq_count;
    logic [CW-1:0]   buf_count;
    logic            pcq_empty;
    logic            pcq_full;
    logic            buf_empty;
    logic            buf_full;
    fetch_entry_t    pcq_in;
    fetch_entry_t    pcq_head;
    fetch_entry_t    buf_in;
    fetch_entry_t    buf_head;

    logic            credit;
    logic            req_fire;
    logic            rsp_live;
    logic            rsp_drop;
    logic            rsp_take;
    logic            if_pop;
    logic            unused_bits;

    // Credit uses cycle-start occupancy so a slot freed this cycle is not reused.
    assign occupancy = {1'b0, inflight} + {1'b0, buf_count};
    assign credit    = (occupancy < (CW+1)'(DEPTH));

    assign imem_req_valid = !reset && !redirect_valid && credit;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_live = imem_rsp_valid && !redirect_valid;
    assign rsp_drop = rsp_live && (drop != '0);
    assign rsp_take = rsp_live && (drop == '0) && (inflight != '0);

    assign if_valid = !buf_empty;
    assign if_pop   = if_valid && if_ready && !redirect_valid;
    assign if_instr = if_valid ? buf_head.instr : NOP_INSTR;
    assign if_pc    = if_valid ? buf_head.pc : '0;

    assign pcq_in = '{pc: fetch_pc, instr: '0};
    assign buf_in = '{pc: pcq_head.pc, instr: imem_rsp_data};

    assign unused_bits = ^{redirect_pc[1:0], pcq_head.instr};

    // Everything still owed by memory becomes stale; a response landing now is one of them.
    always_comb begin
        pending       = {1'b0, drop} + {1'b0, inflight};
        drop_redirect = CW'(pending - (CW+1)'(imem_rsp_valid && (pending != '0)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= '0;
            drop     <= drop_redirect;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            inflight <= inflight + CW'(req_fire) - CW'(rsp_take);
            drop     <= drop - CW'(rsp_drop);
        end
    end

    ifu_fifo #(.DEPTH(DEPTH)) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pcq_in),
        .pop       (rsp_take),
        .head      (pcq_head),
        .count     (pcq_count),
        .empty     (pcq_empty),
        .full      (pcq_full)
    );

    ifu_fifo #(.DEPTH(DEPTH)) u_fetch_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (rsp_take),
        .push_data (buf_in),
        .pop       (if_pop),
        .head      (buf_head),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_valid && (inflight == '0) && (drop == '0)));
            assert (inflight <= CW'(DEPTH));
            assert (drop <= CW'(DEPTH));
            assert (buf_count <= CW'(DEPTH));
            assert (pcq_count == inflight);
            assert (!(req_fire && pcq_full));
            assert (!(rsp_take && pcq_empty));
            assert (!(rsp_take && buf_full && !if_pop));
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a transaction-level
// model: memory transactions are tagged stale on redirect instead of counted.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
        bit          stale;
    } mem_txn_t;

    mem_txn_t    mem_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] seen[$];
    logic [31:0] fired[$];
    logic [31:0] model_pc;
    int unsigned cyc;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          first_valid_cyc;
    logic [31:0] first_valid_pc;
    logic [31:0] first_valid_instr;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int live_count();
        int n = 0;
        foreach (mem_q[i]) if (!mem_q[i].stale) n++;
        return n;
    endfunction

    function automatic logic [31:0] seen_at(input int i);
        return (seen.size() > i) ? seen[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] fired_at(input int i);
        return (fired.size() > i) ? fired[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory response, check outputs, advance the model at the edge.
    task automatic cycle();
        logic        rsp_now;
        logic        exp_rv;
        logic        exp_iv;
        logic        fire;
        logic        pop;
        mem_txn_t    head;
        int unsigned due;
        rsp_now = (mem_q.size() > 0) && (mem_q[0].due == cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data = rsp_now ? mem_word(mem_q[0].addr) : $urandom();
        #1;
        exp_rv = !redirect_valid && ((live_count() + buf_q.size()) < 4);
        exp_iv = (buf_q.size() > 0);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("req_addr", imem_req_addr, model_pc);
        chk("if_valid", 32'(if_valid), 32'(exp_iv));
        chk("if_pc", if_pc, exp_iv ? buf_q[0] : 32'h0);
        chk("if_instr", if_instr, exp_iv ? mem_word(buf_q[0]) : NOP_INSTR);
        if (if_valid && first_valid_cyc < 0) begin
            first_valid_cyc = int'(cyc);
            first_valid_pc = if_pc;
            first_valid_instr = if_instr;
        end
        fire = imem_req_valid && imem_req_ready;
        pop = exp_iv && if_ready && !redirect_valid;
        @(posedge clk);
        if (rsp_now) head = mem_q.pop_front();
        if (redirect_valid) begin
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            buf_q.delete();
            model_pc = word_align(redirect_pc);
        end else begin
            if (pop) begin
                seen.push_back(buf_q[0]);
                void'(buf_q.pop_front());
            end
            if (rsp_now && !head.stale) buf_q.push_back(head.addr);
            if (fire) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
                mem_q.push_back('{due: due, addr: model_pc, stale: 1'b0});
                fired.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        if_ready = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_instr", if_instr, NOP_INSTR);
        chk("rst_if_pc", if_pc, 32'h0);
        mem_q.delete();
        buf_q.delete();
        seen.delete();
        fired.delete();
        model_pc = 32'h0;
        first_valid_cyc = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Streaming with single-cycle memory
        apply_reset();
        lat_lo = 1; lat_hi = 1;
        imem_req_ready = 1'b1; if_ready = 1'b1;
        repeat (8) cycle();
        chk("first_valid_cycle", 32'(first_valid_cyc), 32'd2);
        chk("first_valid_pc", first_valid_pc, 32'h0);
        chk("stream_addr0", fired_at(0), 32'h0);
        chk("stream_addr1", fired_at(1), 32'h4);
        chk("stream_addr2", fired_at(2), 32'h8);

        // Decode stalled: credit limit
        apply_reset();
        imem_req_ready = 1'b1; if_ready = 1'b0;
        repeat (10) cycle();
        chk("stall_issue_count", 32'(fired.size()), 32'd4);
        chk("stall_pc_stable", if_pc, first_valid_pc);
        chk("stall_instr_stable", if_instr, first_valid_instr);
        chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
        if_ready = 1'b1;
        repeat (4) cycle();
        chk("resume_issue", 32'(fired.size() > 4), 32'h1);

        // Redirect with three requests outstanding
        apply_reset();
        lat_lo = 3; lat_hi = 3;
        imem_req_ready = 1'b1; if_ready = 1'b1;
        repeat (3) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        seen.delete(); fired.delete();
        repeat (14) cycle();
        chk("redir_req_addr", fired_at(0), 32'h100);
        chk("redir_pc0", seen_at(0), 32'h100);
        chk("redir_pc1", seen_at(1), 32'h104);
        chk("redir_pc2", seen_at(2), 32'h108);

        // Redirect colliding with a decode pop and a response
        apply_reset();
        lat_lo = 1; lat_hi = 1;
        imem_req_ready = 1'b1; if_ready = 1'b1;
        repeat (2) cycle();
        chk("collide_if_valid", 32'(if_valid), 32'h1);
        seen.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        redirect_valid = 1'b0;
        chk("collide_pop_void", 32'(seen.size()), 32'h0);
        chk("collide_buf_empty", 32'(if_valid), 32'h0);
        repeat (6) cycle();
        chk("collide_next_pc", seen_at(0), 32'h200);

        // Address wrap at the top of memory
        seen.delete(); fired.delete();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect_valid = 1'b0;
        repeat (8) cycle();
        chk("wrap_addr0", fired_at(0), 32'hFFFF_FFF8);
        chk("wrap_addr1", fired_at(1), 32'hFFFF_FFFC);
        chk("wrap_addr2", fired_at(2), 32'h0000_0000);
        chk("wrap_pc0", seen_at(0), 32'hFFFF_FFF8);
        chk("wrap_pc1", seen_at(1), 32'hFFFF_FFFC);
        chk("wrap_pc2", seen_at(2), 32'h0000_0000);

        // Reset in the middle of a burst
        apply_reset();
        lat_lo = 3; lat_hi = 3;
        imem_req_ready = 1'b1; if_ready = 1'b1;
        repeat (2) cycle();
        apply_reset();
        #1;
        chk("post_rst_addr", imem_req_addr, 32'h0);
        chk("post_rst_if_valid", 32'(if_valid), 32'h0);
        chk("post_rst_if_instr", if_instr, NOP_INSTR);
        @(negedge clk);
        cyc = 1;
        imem_req_ready = 1'b1; if_ready = 1'b1;
        repeat (8) cycle();

        // Randomized traffic
        lat_lo = 1; lat_hi = 3;
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            if_ready = ($urandom_range(9, 0) < 7);
            redirect_valid = ($urandom_range(15, 0) == 0);
            redirect_pc = $urandom();
            cycle();
        end
        redirect_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
